wb_boot_copier: RTL and testbench
=================================

Name: wb_boot_copier

Overview:
- Wishbone master that sits directly upstream of the boot ROM.
- After reset (or on a start pulse) it reads WORDS 32-bit words from the boot ROM and writes each one to RAM.
- During the copy it holds the CPU core in reset, and releases it once the copy finishes.
- A missing Wishbone acknowledge is detected by a per-transfer timeout, which reports an error and keeps the CPU held in reset.

Parameters:
- ROM_BASE, 32'h8000_0000, byte address of the first ROM word.
- RAM_BASE, 32'h0000_0000, byte address of the first RAM destination word.
- WORDS, 1024, number of 32-bit words to copy (0 allowed).
- TIMEOUT, 255, cycles to wait for an ack before declaring an error (≥1).
- AUTO_START, 1, 1 = start automatically on the first cycle after reset release.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  start/restart pulse; honoured only in IDLE, DONE, ERR
- o_rom_adr  out  32  ROM Wishbone address
- o_rom_dat  out  32  ROM write data, tied 0
- o_rom_sel  out  4  ROM byte select, tied 4'hF
- o_rom_we  out  1  ROM write enable, tied 0
- o_rom_cyc  out  1  ROM cycle
- o_rom_stb  out  1  ROM strobe
- i_rom_ack  in  1  ROM acknowledge
- i_rom_rdt  in  32  ROM read data
- o_ram_adr  out  32  RAM Wishbone address
- o_ram_dat  out  32  RAM write data
- o_ram_sel  out  4  RAM byte select, 4'hF during writes
- o_ram_we  out  1  RAM write enable
- o_ram_cyc  out  1  RAM cycle
- o_ram_stb  out  1  RAM strobe
- i_ram_ack  in  1  RAM acknowledge
- o_busy  out  1  copy in progress
- o_done  out  1  copy completed successfully
- o_err  out  1  timeout occurred
- o_cpu_rst_n  out  1  CPU reset, active-low; 1 only in DONE
- o_count  out  $clog2(WORDS+1)  words written so far

Behaviour:
Reset (i_rst_n=0 at a clock edge):
- State returns to IDLE.
- All cyc, stb and we outputs are 0; o_busy, o_done and o_err are 0; o_cpu_rst_n is 0.
- o_count, the word index, the timeout counter and the data latch are 0.
- Reset has effect mid-transfer: the bus is abandoned in the same edge, with no completion.

States:
- IDLE
  - Goes to RD if AUTO_START=1 on the first cycle after reset release, or when i_start=1.
  - If WORDS=0, goes to DONE instead of RD.
- RD
  - o_rom_cyc=o_rom_stb=1.
  - o_rom_adr = ROM_BASE + 4*idx.
  - When i_rom_ack=1, latch i_rom_rdt and go to WR at the next edge.
  - cyc and stb drop in that next cycle.
- WR
  - o_ram_cyc=o_ram_stb=o_ram_we=1, o_ram_sel=4'hF.
  - o_ram_adr = RAM_BASE + 4*idx; o_ram_dat = latched word.
  - When i_ram_ack=1, o_count increments.
  - If idx = WORDS-1, go to DONE; otherwise increment idx and go to RD.
- DONE
  - o_done=1, o_cpu_rst_n=1, bus idle.
  - i_start clears o_count and idx, forces o_cpu_rst_n=0 and goes to RD.
- ERR
  - o_err=1, o_cpu_rst_n=0, bus idle. o_count is frozen.
  - i_start clears o_err, o_count and idx, and goes to RD.

Other rules:
- o_busy=1 exactly in RD and WR.
- Timeout:
  - The counter clears on entry to RD or WR and increments on each cycle in that state without the relevant ack.
  - When the counter equals TIMEOUT with no ack, go to ERR at the next edge.
  - An ack arriving in the same cycle as the timeout wins: the transfer completes.
- Acks are ignored outside their own state: i_rom_ack outside RD, i_ram_ack outside WR, and any ack in IDLE, DONE or ERR.
- i_start while busy is ignored.
- Minimum cost is 2 cycles per word with combinational acks, and 4 cycles per word with single-cycle registered acks (ROM stb, ack, RAM stb, ack).
- Address arithmetic is 32-bit and wraps modulo 2^32; no bounds checking.
- Outputs are registered where practical; o_rom_adr and o_ram_adr may be decoded from state and idx but must be glitch-stable within a cycle.

Test Plan:
1. WORDS=4, AUTO_START=1; ROM model with registered 1-cycle ack returning 32'hA0+idx → RAM writes A0..A3 to 0x0,0x4,0x8,0xC in order; o_count reaches 4; o_done=1 and o_cpu_rst_n=1 at cycle 16±1 after reset release; o_busy=0 afterwards.
2. AUTO_START=0, WORDS=2 → stays in IDLE with no bus activity for 20 cycles; i_start pulse → copy runs; ROM reads at 0x8000_0000 and 0x8000_0004.
3. TIMEOUT=8, RAM never acks on word 1 → o_err=1 exactly 9 cycles after WR entry; o_count=1; o_ram_cyc=0; o_cpu_rst_n=0. Then i_start with a working RAM → full copy completes, o_err=0.
4. Reset asserted in the 2nd cycle of an RD with stb high → next cycle all cyc/stb=0 and o_count=0; after release, restart from word 0.
5. WORDS=0 → DONE one cycle after reset release, with no cyc ever asserted.
6. Stray i_ram_ack pulses during RD and i_rom_ack pulses during DONE → no state change, no count change; data integrity over WORDS=16 with random 0–5 cycle ack delays; RAM contents equal the ROM image.

Source files
------------

// File: rtl/wb_boot_copier.sv
// Boot copier: Wishbone master that copies WORDS 32-bit words from boot ROM
// to RAM while holding the CPU in reset, with a per-transfer ack timeout.

module wb_boot_copier #(
   parameter logic [31:0]  ROM_BASE   = 32'h8000_0000,
   parameter logic [31:0]  RAM_BASE   = 32'h0000_0000,
   parameter int unsigned  WORDS      = 1024,
   parameter int unsigned  TIMEOUT    = 255,
   parameter bit           AUTO_START = 1'b1,
   localparam int unsigned CW         = (WORDS > 0) ? $clog2(WORDS + 1) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   output logic [31:0]   o_rom_adr,
   output logic [31:0]   o_rom_dat,
   output logic [3:0]    o_rom_sel,
   output logic          o_rom_we,
   output logic          o_rom_cyc,
   output logic          o_rom_stb,
   input  logic          i_rom_ack,
   input  logic [31:0]   i_rom_rdt,
   output logic [31:0]   o_ram_adr,
   output logic [31:0]   o_ram_dat,
   output logic [3:0]    o_ram_sel,
   output logic          o_ram_we,
   output logic          o_ram_cyc,
   output logic          o_ram_stb,
   input  logic          i_ram_ack,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic          o_cpu_rst_n,
   output logic [CW-1:0] o_count
);

   localparam int unsigned   IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'((WORDS > 0) ? WORDS - 1 : 0);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
   localparam bit            EMPTY     = (WORDS == 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state_q;
   logic          auto_q;
   logic [IW-1:0] idx_q;
   logic [CW-1:0] count_q;
   logic [TW-1:0] tmo_q;
   logic [31:0]   data_q;
   logic          rom_req_q;
   logic          ram_req_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          cpu_rst_n_q;

   // Addresses are decoded from registered idx only, so they cannot glitch.
   assign o_rom_adr   = ROM_BASE + (32'(idx_q) << 2);
   assign o_rom_dat   = '0;
   assign o_rom_sel   = 4'hF;
   assign o_rom_we    = 1'b0;
   assign o_rom_cyc   = rom_req_q;
   assign o_rom_stb   = rom_req_q;

   assign o_ram_adr   = RAM_BASE + (32'(idx_q) << 2);
   assign o_ram_dat   = data_q;
   assign o_ram_sel   = {4{ram_req_q}};
   assign o_ram_we    = ram_req_q;
   assign o_ram_cyc   = ram_req_q;
   assign o_ram_stb   = ram_req_q;

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_err       = err_q;
   assign o_cpu_rst_n = cpu_rst_n_q;
   assign o_count     = count_q;

   // NOTE: every register here, outputs included, is updated with <= in one
   // clocked block so all of them change together on the same edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         auto_q      <= AUTO_START;
         idx_q       <= '0;
         count_q     <= '0;
         tmo_q       <= '0;
         data_q      <= '0;
         rom_req_q   <= 1'b0;
         ram_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         auto_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (auto_q || i_start) begin
                  if (EMPTY) begin
                     state_q     <= S_DONE;
                     done_q      <= 1'b1;
                     cpu_rst_n_q <= 1'b1;
                  end else begin
                     state_q   <= S_RD;
                     rom_req_q <= 1'b1;
                     busy_q    <= 1'b1;
                     tmo_q     <= '0;
                  end
               end
            end

            S_RD: begin
               // An ack in the timeout cycle still completes the transfer.
               if (i_rom_ack) begin
                  data_q    <= i_rom_rdt;
                  rom_req_q <= 1'b0;
                  ram_req_q <= 1'b1;
                  tmo_q     <= '0;
                  state_q   <= S_WR;
               end else if (tmo_q == TMO_LIMIT) begin
                  rom_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_ERR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end

            S_WR: begin
               if (i_ram_ack) begin
                  count_q   <= count_q + CW'(1);
                  ram_req_q <= 1'b0;
                  tmo_q     <= '0;
                  if (idx_q == LAST_IDX) begin
                     state_q     <= S_DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     cpu_rst_n_q <= 1'b1;
                  end else begin
                     idx_q     <= idx_q + IW'(1);
                     rom_req_q <= 1'b1;
                     state_q   <= S_RD;
                  end
               end else if (tmo_q == TMO_LIMIT) begin
                  ram_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_ERR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end

            S_DONE: begin
               // With nothing to copy a restart has no work, so DONE holds.
               if (i_start && !EMPTY) begin
                  done_q      <= 1'b0;
                  cpu_rst_n_q <= 1'b0;
                  count_q     <= '0;
                  idx_q       <= '0;
                  tmo_q       <= '0;
                  rom_req_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_RD;
               end
            end

            S_ERR: begin
               if (i_start) begin
                  err_q     <= 1'b0;
                  count_q   <= '0;
                  idx_q     <= '0;
                  tmo_q     <= '0;
                  rom_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_RD;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_boot_copier.sv
// Bench for wb_boot_copier: three instances (manual start, auto start, empty
// copy) driven by randomised Wishbone slave models and a ROM/RAM image model.

module tb_wb_boot_copier;

   localparam logic [31:0] ROM_BASE   = 32'h8000_0000;
   localparam logic [31:0] M_RAM_BASE = 32'h2000_0100;
   localparam int          M_WORDS    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- main instance: WORDS=16, TIMEOUT=8, manual start
   logic        rst_n, m_start;
   logic [31:0] m_rom_adr, m_rom_dat, m_rom_rdt, m_ram_adr, m_ram_dat;
   logic [3:0]  m_rom_sel, m_ram_sel;
   logic        m_rom_we, m_rom_cyc, m_rom_stb, m_rom_ack;
   logic        m_ram_we, m_ram_cyc, m_ram_stb, m_ram_ack;
   logic        m_busy, m_done, m_err, m_cpu_rst_n;
   logic [4:0]  m_count;

   wb_boot_copier #(.ROM_BASE(ROM_BASE), .RAM_BASE(M_RAM_BASE), .WORDS(M_WORDS),
                    .TIMEOUT(8), .AUTO_START(1'b0)) u_main (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(m_start),
      .o_rom_adr(m_rom_adr), .o_rom_dat(m_rom_dat), .o_rom_sel(m_rom_sel),
      .o_rom_we(m_rom_we), .o_rom_cyc(m_rom_cyc), .o_rom_stb(m_rom_stb),
      .i_rom_ack(m_rom_ack), .i_rom_rdt(m_rom_rdt),
      .o_ram_adr(m_ram_adr), .o_ram_dat(m_ram_dat), .o_ram_sel(m_ram_sel),
      .o_ram_we(m_ram_we), .o_ram_cyc(m_ram_cyc), .o_ram_stb(m_ram_stb),
      .i_ram_ack(m_ram_ack),
      .o_busy(m_busy), .o_done(m_done), .o_err(m_err),
      .o_cpu_rst_n(m_cpu_rst_n), .o_count(m_count)
   );

   // ---------------- auto-start instance: WORDS=4, default bases
   logic        rst_b_n;
   logic [31:0] b_rom_adr, b_rom_dat, b_rom_rdt, b_ram_adr, b_ram_dat;
   logic [3:0]  b_rom_sel, b_ram_sel;
   logic        b_rom_we, b_rom_cyc, b_rom_stb, b_rom_ack = 1'b0;
   logic        b_ram_we, b_ram_cyc, b_ram_stb, b_ram_ack = 1'b0;
   logic        b_busy, b_done, b_err, b_cpu_rst_n;
   logic [2:0]  b_count;

   wb_boot_copier #(.WORDS(4), .TIMEOUT(255), .AUTO_START(1'b1)) u_auto (
      .i_clk(clk), .i_rst_n(rst_b_n), .i_start(1'b0),
      .o_rom_adr(b_rom_adr), .o_rom_dat(b_rom_dat), .o_rom_sel(b_rom_sel),
      .o_rom_we(b_rom_we), .o_rom_cyc(b_rom_cyc), .o_rom_stb(b_rom_stb),
      .i_rom_ack(b_rom_ack), .i_rom_rdt(b_rom_rdt),
      .o_ram_adr(b_ram_adr), .o_ram_dat(b_ram_dat), .o_ram_sel(b_ram_sel),
      .o_ram_we(b_ram_we), .o_ram_cyc(b_ram_cyc), .o_ram_stb(b_ram_stb),
      .i_ram_ack(b_ram_ack),
      .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
      .o_cpu_rst_n(b_cpu_rst_n), .o_count(b_count)
   );

   // ---------------- empty instance: WORDS=0
   logic        rst_c_n;
   logic [31:0] c_rom_adr, c_rom_dat, c_ram_adr, c_ram_dat;
   logic [3:0]  c_rom_sel, c_ram_sel;
   logic        c_rom_we, c_rom_cyc, c_rom_stb, c_ram_we, c_ram_cyc, c_ram_stb;
   logic        c_busy, c_done, c_err, c_cpu_rst_n;
   logic [0:0]  c_count;

   wb_boot_copier #(.WORDS(0), .AUTO_START(1'b1)) u_empty (
      .i_clk(clk), .i_rst_n(rst_c_n), .i_start(1'b0),
      .o_rom_adr(c_rom_adr), .o_rom_dat(c_rom_dat), .o_rom_sel(c_rom_sel),
      .o_rom_we(c_rom_we), .o_rom_cyc(c_rom_cyc), .o_rom_stb(c_rom_stb),
      .i_rom_ack(1'b0), .i_rom_rdt(32'h0),
      .o_ram_adr(c_ram_adr), .o_ram_dat(c_ram_dat), .o_ram_sel(c_ram_sel),
      .o_ram_we(c_ram_we), .o_ram_cyc(c_ram_cyc), .o_ram_stb(c_ram_stb),
      .i_ram_ack(1'b0),
      .o_busy(c_busy), .o_done(c_done), .o_err(c_err),
      .o_cpu_rst_n(c_cpu_rst_n), .o_count(c_count)
   );

   // ---------------- main slave models and memory image
   logic [31:0] rom_img [M_WORDS];
   logic [31:0] ram_mem [M_WORDS];
   logic [31:0] rom_rd_log [$];
   logic [31:0] rom_off, ram_off;
   logic        rom_ack_mdl = 1'b0, ram_ack_mdl = 1'b0;
   logic        rom_ack_stray, ram_ack_stray;
   int          rom_wait = 0, rom_delay = 0, ram_wait = 0, ram_delay = 0;
   int          max_delay = 0;
   int          rom_hold_idx = -1, ram_hold_idx = -1;
   int          bus_err_cnt = 0;
   int          cyc_cnt_m = 0, cyc_cnt_c = 0;

   assign rom_off   = (m_rom_adr - ROM_BASE) >> 2;
   assign ram_off   = (m_ram_adr - M_RAM_BASE) >> 2;
   assign m_rom_ack = rom_ack_mdl | rom_ack_stray;
   assign m_ram_ack = ram_ack_mdl | ram_ack_stray;

   always @(posedge clk) begin
      rom_ack_mdl <= 1'b0;
      if (!(m_rom_cyc && m_rom_stb)) begin
         rom_wait <= 0;
      end else if (!rom_ack_mdl && int'(rom_off) != rom_hold_idx) begin
         if (m_rom_we !== 1'b0 || m_rom_sel !== 4'hF) bus_err_cnt++;
         if (rom_wait >= rom_delay) begin
            rom_ack_mdl <= 1'b1;
            m_rom_rdt   <= rom_img[rom_off[3:0]];
            rom_wait    <= 0;
            rom_delay   <= $urandom_range(0, max_delay);
            rom_rd_log.push_back(m_rom_adr);
         end else begin
            rom_wait <= rom_wait + 1;
         end
      end
   end

   always @(posedge clk) begin
      ram_ack_mdl <= 1'b0;
      if (!(m_ram_cyc && m_ram_stb)) begin
         ram_wait <= 0;
      end else if (!ram_ack_mdl && int'(ram_off) != ram_hold_idx) begin
         if (m_ram_we !== 1'b1 || m_ram_sel !== 4'hF) bus_err_cnt++;
         if (ram_wait >= ram_delay) begin
            ram_ack_mdl <= 1'b1;
            ram_mem[ram_off[3:0]] = m_ram_dat;
            ram_wait    <= 0;
            ram_delay   <= $urandom_range(0, max_delay);
         end else begin
            ram_wait <= ram_wait + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (m_rom_cyc || m_ram_cyc) cyc_cnt_m++;
      if (c_rom_cyc || c_ram_cyc) cyc_cnt_c++;
   end

   // ---------------- auto instance: single-cycle registered acks, ROM word = A0+idx
   logic [31:0] b_wr_adr_log [$];
   logic [31:0] b_wr_dat_log [$];

   always @(posedge clk) begin
      b_rom_ack <= b_rom_cyc && b_rom_stb && !b_rom_ack;
      b_rom_rdt <= 32'hA0 + ((b_rom_adr - ROM_BASE) >> 2);
      b_ram_ack <= b_ram_cyc && b_ram_stb && !b_ram_ack;
      if (b_ram_cyc && b_ram_stb && !b_ram_ack) begin
         b_wr_adr_log.push_back(b_ram_adr);
         b_wr_dat_log.push_back(b_ram_dat);
      end
   end

   // ---------------- helpers (no comparisons inside)
   task automatic pulse_start();
      m_start = 1'b1;
      @(negedge clk);
      m_start = 1'b0;
   endtask

   task automatic wait_main_done(input int limit, output bit ok);
      int k = 0;
      while (m_done !== 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
      ok = (m_done === 1'b1);
   endtask

   task automatic new_image();
      for (int i = 0; i < M_WORDS; i++) begin
         rom_img[i] = $urandom;
         ram_mem[i] = ~rom_img[i];
      end
      rom_rd_log.delete();
   endtask

   function automatic int mem_mismatches();
      int n = 0;
      for (int i = 0; i < M_WORDS; i++)
         if (ram_mem[i] !== rom_img[i]) n++;
      return n;
   endfunction

   function automatic int rom_log_mismatches();
      int n = (rom_rd_log.size() == M_WORDS) ? 0 : 1;
      for (int i = 0; i < rom_rd_log.size() && i < M_WORDS; i++)
         if (rom_rd_log[i] !== ROM_BASE + 32'(4 * i)) n++;
      return n;
   endfunction

   // ---------------- scenarios
   task automatic test_reset();
      logic [8:0] ctl;
      repeat (3) @(negedge clk);
      ctl = {m_rom_cyc, m_rom_stb, m_ram_cyc, m_ram_stb, m_ram_we,
             m_busy, m_done, m_err, m_cpu_rst_n};
      checks++;
      if (ctl !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected 000000000", ctl);
      end
      checks++;
      if (m_count !== 5'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", m_count);
      end
      checks++;
      if ({m_rom_we, m_rom_sel, m_rom_dat} !== {1'b0, 4'hF, 32'h0}) begin
         errors++;
         $display("FAIL rom_ties: we=%b sel=%h dat=%h expected 0/f/0", m_rom_we, m_rom_sel, m_rom_dat);
      end
   endtask

   task automatic test_idle_no_auto();
      int snap;
      rst_n = 1'b1;
      snap  = cyc_cnt_m;
      repeat (20) @(negedge clk);
      checks++;
      if (cyc_cnt_m != snap || m_busy !== 1'b0 || m_done !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_auto: cyc_cycles=%0d busy=%b done=%b expected 0/0/0", cyc_cnt_m - snap, m_busy, m_done);
      end
   endtask

   task automatic test_copy_random();
      bit ok;
      bit stray_done;
      int c;
      int k;
      new_image();
      max_delay   = 5;
      bus_err_cnt = 0;
      stray_done  = 1'b0;
      k = 0;
      pulse_start();
      while (m_done !== 1'b1 && k < 3000) begin
         if (!stray_done && m_rom_stb === 1'b1 && m_count == 5'd5) begin
            c = int'(m_count);
            ram_ack_stray = 1'b1;
            m_start       = 1'b1;
            @(negedge clk);
            ram_ack_stray = 1'b0;
            m_start       = 1'b0;
            stray_done    = 1'b1;
            checks++;
            if (int'(m_count) != c || m_busy !== 1'b1) begin
               errors++;
               $display("FAIL stray_ram_ack_in_rd: count=%0d busy=%b expected count=%0d busy=1", m_count, m_busy, c);
            end
         end else begin
            @(negedge clk);
            k++;
         end
      end
      ok = (m_done === 1'b1);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL copy_timeout: done=%b expected 1 within budget", m_done);
      end
      checks++;
      if (m_count !== 5'd16 || m_cpu_rst_n !== 1'b1 || m_busy !== 1'b0 || m_err !== 1'b0) begin
         errors++;
         $display("FAIL copy_end_state: count=%0d cpu_rst_n=%b busy=%b err=%b expected 16/1/0/0", m_count, m_cpu_rst_n, m_busy, m_err);
      end
      checks++;
      if (mem_mismatches() != 0) begin
         errors++;
         $display("FAIL copy_data: %0d RAM words differ expected 0", mem_mismatches());
      end
      checks++;
      if (rom_log_mismatches() != 0) begin
         errors++;
         $display("FAIL copy_rom_addr: %0d address errors over %0d reads expected 0", rom_log_mismatches(), rom_rd_log.size());
      end
      checks++;
      if (bus_err_cnt != 0) begin
         errors++;
         $display("FAIL copy_bus_ctl: %0d bad we/sel cycles expected 0", bus_err_cnt);
      end
      rom_ack_stray = 1'b1;
      repeat (3) @(negedge clk);
      rom_ack_stray = 1'b0;
      @(negedge clk);
      checks++;
      if (m_done !== 1'b1 || m_count !== 5'd16 || m_rom_cyc !== 1'b0 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_rom_ack_in_done: done=%b count=%0d rom_cyc=%b busy=%b expected 1/16/0/0", m_done, m_count, m_rom_cyc, m_busy);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int k;
      int n;
      max_delay    = 0;
      ram_hold_idx = 1;
      pulse_start();
      checks++;
      if (m_cpu_rst_n !== 1'b0 || m_count !== 5'd0 || m_done !== 1'b0) begin
         errors++;
         $display("FAIL restart_from_done: cpu_rst_n=%b count=%0d done=%b expected 0/0/0", m_cpu_rst_n, m_count, m_done);
      end
      k = 0;
      while (!(m_ram_cyc === 1'b1 && m_ram_adr === M_RAM_BASE + 32'd4) && k < 200) begin
         @(negedge clk);
         k++;
      end
      n = 0;
      while (m_err !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL timeout_latency: err after %0d cycles expected 9", n);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (m_err !== 1'b1 || m_count !== 5'd1 || m_ram_cyc !== 1'b0 || m_cpu_rst_n !== 1'b0 || m_busy !== 1'b0) begin
         errors++;
         $display("FAIL err_state: err=%b count=%0d ram_cyc=%b cpu_rst_n=%b busy=%b expected 1/1/0/0/0", m_err, m_count, m_ram_cyc, m_cpu_rst_n, m_busy);
      end
      ram_hold_idx = -1;
      max_delay    = 3;
      new_image();
      pulse_start();
      checks++;
      if (m_err !== 1'b0 || m_count !== 5'd0 || m_busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_from_err: err=%b count=%0d busy=%b expected 0/0/1", m_err, m_count, m_busy);
      end
      wait_main_done(3000, ok);
      checks++;
      if (!ok || m_err !== 1'b0 || m_count !== 5'd16 || mem_mismatches() != 0) begin
         errors++;
         $display("FAIL recopy_after_err: done=%b err=%b count=%0d bad_words=%0d expected 1/0/16/0", m_done, m_err, m_count, mem_mismatches());
      end
   endtask

   task automatic test_reset_mid_rd();
      bit ok;
      int k;
      max_delay    = 2;
      rom_hold_idx = 3;
      pulse_start();
      k = 0;
      while (!(m_rom_stb === 1'b1 && m_rom_adr === ROM_BASE + 32'd12) && k < 500) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_rom_cyc, m_rom_stb, m_ram_cyc, m_ram_stb, m_busy, m_cpu_rst_n} !== 6'b0 || m_count !== 5'd0) begin
         errors++;
         $display("FAIL reset_mid_rd: cyc/stb/busy/cpu=%b count=%0d expected 000000 and 0",
                  {m_rom_cyc, m_rom_stb, m_ram_cyc, m_ram_stb, m_busy, m_cpu_rst_n}, m_count);
      end
      rst_n        = 1'b1;
      rom_hold_idx = -1;
      new_image();
      repeat (2) @(negedge clk);
      pulse_start();
      wait_main_done(3000, ok);
      checks++;
      if (!ok || rom_log_mismatches() != 0 || mem_mismatches() != 0 || m_count !== 5'd16) begin
         errors++;
         $display("FAIL restart_after_reset: done=%b addr_errs=%0d bad_words=%0d count=%0d expected 1/0/0/16",
                  m_done, rom_log_mismatches(), mem_mismatches(), m_count);
      end
   endtask

   task automatic test_auto_start();
      int n;
      int bad;
      rst_b_n = 1'b1;
      n = 0;
      while (b_done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 15 || n > 17) begin
         errors++;
         $display("FAIL auto_latency: done after %0d cycles expected 15..17", n);
      end
      checks++;
      if (b_cpu_rst_n !== 1'b1 || b_count !== 3'd4 || b_err !== 1'b0) begin
         errors++;
         $display("FAIL auto_end_state: cpu_rst_n=%b count=%0d err=%b expected 1/4/0", b_cpu_rst_n, b_count, b_err);
      end
      bad = (b_wr_adr_log.size() == 4) ? 0 : 1;
      for (int i = 0; i < b_wr_adr_log.size() && i < 4; i++)
         if (b_wr_adr_log[i] !== 32'(4 * i) || b_wr_dat_log[i] !== 32'hA0 + 32'(i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL auto_writes: %0d bad writes of %0d expected 0", bad, b_wr_adr_log.size());
      end
      repeat (5) @(negedge clk);
      checks++;
      if (b_busy !== 1'b0 || b_done !== 1'b1 || b_ram_cyc !== 1'b0) begin
         errors++;
         $display("FAIL auto_idle_after: busy=%b done=%b ram_cyc=%b expected 0/1/0", b_busy, b_done, b_ram_cyc);
      end
   endtask

   task automatic test_words_zero();
      rst_c_n = 1'b1;
      @(negedge clk);
      checks++;
      if (c_done !== 1'b1 || c_cpu_rst_n !== 1'b1 || c_busy !== 1'b0 || c_count !== 1'b0) begin
         errors++;
         $display("FAIL empty_done: done=%b cpu_rst_n=%b busy=%b count=%0d expected 1/1/0/0", c_done, c_cpu_rst_n, c_busy, c_count);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (cyc_cnt_c != 0 || c_done !== 1'b1) begin
         errors++;
         $display("FAIL empty_no_bus: cyc_cycles=%0d done=%b expected 0/1", cyc_cnt_c, c_done);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      rst_b_n       = 1'b0;
      rst_c_n       = 1'b0;
      m_start       = 1'b0;
      rom_ack_stray = 1'b0;
      ram_ack_stray = 1'b0;
      for (int i = 0; i < M_WORDS; i++) begin
         rom_img[i] = 32'h0;
         ram_mem[i] = 32'h0;
      end
      test_reset();
      test_idle_no_auto();
      test_copy_random();
      test_timeout();
      test_reset_mid_rd();
      test_auto_start();
      test_words_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
